time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_S, default 30, giving the number of idle seconds in a set state before the edit is abandoned.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; all logic is synchronous to its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port clk_1hz_en, input, 1 bit: a one-cycle pulse once per second; it drives the timeout count.
REQ-005 The block SHALL have port blink_en, input, 1 bit: a one-cycle pulse at 2 Hz; it drives the blink toggle.
REQ-006 The block SHALL have port btn_mode, input, 1 bit: a debounced single-cycle press pulse.
REQ-007 The block SHALL have port btn_inc, input, 1 bit: a debounced single-cycle press pulse.
REQ-008 The block SHALL have port btn_dec, input, 1 bit: a debounced single-cycle press pulse.
REQ-009 The block SHALL have port cur_hour, input, 5 bits: the live hour from the time counter, 0..23.
REQ-010 The block SHALL have port cur_min, input, 6 bits: the live minute from the time counter, 0..59.
REQ-011 The block SHALL have port time_count_en, output, 1 bit: enables time counting.
REQ-012 The block SHALL have port load_en, output, 1 bit: a one-cycle load strobe to the time counter.
REQ-013 The block SHALL have port hour_in, output, 5 bits: the edited hour.
REQ-014 The block SHALL have port min_in, output, 6 bits: the edited minute.
REQ-015 The block SHALL have port mode, output, 2 bits: the state code (RUN=0, SET_HOUR=1, SET_MIN=2, COMMIT=3).
REQ-016 The block SHALL have port blink_hour, output, 1 bit: hour-digit blanking for the display, 1 = blank.
REQ-017 The block SHALL have port blink_min, output, 1 bit: minute-digit blanking for the display, 1 = blank.

Function
REQ-018 The FSM SHALL have four states (RUN, SET_HOUR, SET_MIN, COMMIT), with all outputs registered or decoded from registered state only.
REQ-019 From RUN, btn_mode SHALL move the FSM to SET_HOUR in the same edge and capture cur_hour/cur_min into edit_hour/edit_min.
REQ-020 From SET_HOUR, btn_mode SHALL move the FSM to SET_MIN; from SET_MIN, btn_mode SHALL move it to COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle with load_en=1, then go unconditionally to RUN; all inputs are ignored in COMMIT.
REQ-022 load_en SHALL be 1 only in COMMIT and never two consecutive cycles.
REQ-023 time_count_en SHALL be 1 only in RUN; it SHALL be 0 in SET_HOUR, SET_MIN and COMMIT.
REQ-024 hour_in/min_in SHALL continuously drive edit_hour/edit_min; these registers change only on capture or inc/dec.
REQ-025 In SET_HOUR, btn_inc SHALL set edit_hour+1 with wrap 23->0, and btn_dec SHALL set edit_hour-1 with wrap 0->23.
REQ-026 In SET_MIN, btn_inc/btn_dec SHALL adjust edit_min the same way with wrap 59->0 and 0->59.
REQ-027 inc/dec SHALL have no effect in RUN and COMMIT.
REQ-028 If btn_inc and btn_dec are both 1 in the same cycle, the edit value SHALL be unchanged.
REQ-029 If btn_mode coincides with btn_inc or btn_dec, the mode transition SHALL take effect and the inc/dec SHALL be ignored.
REQ-030 An idle counter (width ceil(log2(TIMEOUT_S+1))) SHALL clear on state entry and on any button pulse, and otherwise increment on clk_1hz_en while in SET_HOUR/SET_MIN.
REQ-031 When the idle counter reaches TIMEOUT_S, the FSM SHALL return to RUN without load_en, discarding the edit, with time_count_en=1 from the next cycle.
REQ-032 A blink toggle SHALL flip on blink_en in set states and be forced to 0 in RUN and COMMIT, and on entry to any set state.
REQ-033 blink_hour SHALL equal toggle AND (state==SET_HOUR).
REQ-034 blink_min SHALL equal toggle AND (state==SET_MIN).
REQ-035 A button pulse in a set state SHALL clear the toggle so that the digit is visible immediately after adjustment.

Reset
REQ-036 While rst=1, the block SHALL hold state=RUN, edit_hour=0, edit_min=0, idle=0, toggle=0.
REQ-037 While rst=1, outputs SHALL be: time_count_en=1, load_en=0, hour_in=0, min_in=0, mode=0, blink_hour=0, blink_min=0.
REQ-038 Reset asserted mid-edit or in COMMIT SHALL abort with no load_en pulse emitted.

Verification
REQ-039 The bench SHALL check full set: cur=13:45, mode, inc x2, mode, dec x1, mode -> exactly one load_en cycle with hour_in=15, min_in=44, then RUN with time_count_en=1.
REQ-040 The bench SHALL check hour wrap: edit_hour=23 + inc -> 0, then dec -> 23.
REQ-041 The bench SHALL check minute wrap: edit_min=59 + inc -> 0, then dec -> 59.
REQ-042 The bench SHALL check simultaneous inputs: inc+dec together -> edit value unchanged; mode+inc together in SET_HOUR -> SET_MIN with edit_hour unchanged.
REQ-043 The bench SHALL check timeout: TIMEOUT_S=3, enter SET_MIN, idle for 3 clk_1hz_en pulses -> RUN with no load_en pulse.
REQ-044 The bench SHALL check reset during SET_MIN -> state RUN, all outputs at reset values, and no load_en pulse.

Source files
------------

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Button-driven time-setting controller for a 24-hour HH:MM clock. It sequences
// RUN -> SET_HOUR -> SET_MIN -> COMMIT -> RUN. It holds the edited hour and
// minute, wraps them on inc/dec, and blinks the digit being edited. A one-cycle
// load strobe is issued in COMMIT. The edit is abandoned after TIMEOUT_S idle
// seconds.
//
// Parameters
//   TIMEOUT_S      idle seconds in a set state before the edit is abandoned
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   clk_1hz_en     one-cycle pulse per second (idle timeout time base)
//   blink_en       one-cycle pulse at 2 Hz (blink time base)
//   btn_mode       debounced press pulse: advance through the set sequence
//   btn_inc        debounced press pulse: increment the field being edited
//   btn_dec        debounced press pulse: decrement the field being edited
//   cur_hour       live hour from the time counter, 0..23
//   cur_min        live minute from the time counter, 0..59
//   time_count_en  1 while in RUN; the time counter advances only then
//   load_en        one-cycle strobe in COMMIT to load hour_in/min_in
//   hour_in        edited hour
//   min_in         edited minute
//   mode           state code: RUN=0, SET_HOUR=1, SET_MIN=2, COMMIT=3
//   blink_hour     1 = blank the hour digits
//   blink_min      1 = blank the minute digits
// -----------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_en,
  input  logic       blink_en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       time_count_en,
  output logic       load_en,
  output logic [4:0] hour_in,
  output logic [5:0] min_in,
  output logic [1:0] mode,
  output logic       blink_hour,
  output logic       blink_min
);

  localparam int IDLE_W = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_S);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  state_t            state,     state_nx;
  logic [4:0]        edit_hour, edit_hour_nx;
  logic [5:0]        edit_min,  edit_min_nx;
  logic [IDLE_W-1:0] idle,      idle_nx;
  logic              toggle,    toggle_nx;

  logic any_btn;
  logic adj_up;
  logic adj_dn;

  // inc and dec pressed together cancel out.
  assign any_btn = btn_mode | btn_inc | btn_dec;
  assign adj_up  = btn_inc & ~btn_dec;
  assign adj_dn  = btn_dec & ~btn_inc;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      edit_hour <= '0;
      edit_min  <= '0;
      idle      <= '0;
      toggle    <= 1'b0;
    end else begin
      state     <= state_nx;
      edit_hour <= edit_hour_nx;
      edit_min  <= edit_min_nx;
      idle      <= idle_nx;
      toggle    <= toggle_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    edit_hour_nx = edit_hour;
    edit_min_nx  = edit_min;
    idle_nx      = idle;
    toggle_nx    = toggle;

    unique case (state)
      RUN: begin
        idle_nx   = '0;
        toggle_nx = 1'b0;
        if (btn_mode) begin
          state_nx     = SET_HOUR;
          edit_hour_nx = cur_hour;
          edit_min_nx  = cur_min;
        end
      end

      SET_HOUR, SET_MIN: begin
        // Idle timeout abandons the edit. Nothing is loaded.
        if (idle == IDLE_MAX) begin
          state_nx = RUN;
        end else if (btn_mode) begin
          // A mode press wins over a coincident inc/dec.
          state_nx = (state == SET_HOUR) ? SET_MIN : COMMIT;
        end else if (state == SET_HOUR) begin
          if (adj_up)
            edit_hour_nx = (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
          else if (adj_dn)
            edit_hour_nx = (edit_hour == 5'd0) ? 5'd23 : edit_hour - 5'd1;
        end else begin
          if (adj_up)
            edit_min_nx = (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
          else if (adj_dn)
            edit_min_nx = (edit_min == 6'd0) ? 6'd59 : edit_min - 6'd1;
        end

        // Any press restarts the idle count and makes the digit visible.
        if (any_btn) begin
          idle_nx   = '0;
          toggle_nx = 1'b0;
        end else begin
          if (clk_1hz_en)
            idle_nx = idle + IDLE_W'(1);
          if (blink_en)
            toggle_nx = ~toggle;
        end
      end

      COMMIT: begin
        state_nx  = RUN;
        idle_nx   = '0;
        toggle_nx = 1'b0;
      end

      default: begin
        state_nx = RUN;
      end
    endcase

    // A fresh state always starts with a clear idle count and visible digits.
    if (state_nx != state) begin
      idle_nx   = '0;
      toggle_nx = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  assign time_count_en = (state == RUN);
  assign load_en       = (state == COMMIT);
  assign hour_in       = edit_hour;
  assign min_in        = edit_min;
  assign mode          = state;
  assign blink_hour    = toggle & (state == SET_HOUR);
  assign blink_min     = toggle & (state == SET_MIN);

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Directed self-checking bench for time_set_ctrl, built with TIMEOUT_S = 3.
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge. A background monitor counts load_en cycles and flags back-to-back
// strobes.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1hz_en;
  logic       blink_en;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic       time_count_en;
  logic       load_en;
  logic [4:0] hour_in;
  logic [5:0] min_in;
  logic [1:0] mode;
  logic       blink_hour;
  logic       blink_min;

  int n_cmp    = 0;
  int n_err    = 0;
  int load_cnt = 0;
  logic prev_load = 1'b0;

  time_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_1hz_en    (clk_1hz_en),
    .blink_en      (blink_en),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .btn_dec       (btn_dec),
    .cur_hour      (cur_hour),
    .cur_min       (cur_min),
    .time_count_en (time_count_en),
    .load_en       (load_en),
    .hour_in       (hour_in),
    .min_in        (min_in),
    .mode          (mode),
    .blink_hour    (blink_hour),
    .blink_min     (blink_min)
  );

  always #5 clk = ~clk;

  // load_en monitor: counts strobe cycles and rejects two in a row.
  always @(negedge clk) begin
    if (load_en === 1'b1) begin
      load_cnt++;
      n_cmp++;
      if (prev_load === 1'b1) begin
        n_err++;
        $display("FAIL load_en_consecutive: got 2 cycles in a row, want 1");
      end
    end
    prev_load = load_en;
  end

  // One-cycle pulse of the selected inputs, then one idle cycle boundary.
  task automatic pulse(input logic m, input logic i, input logic d,
                       input logic hz, input logic bl);
    @(negedge clk);
    btn_mode = m; btn_inc = i; btn_dec = d; clk_1hz_en = hz; blink_en = bl;
    @(negedge clk);
    btn_mode = 0; btn_inc = 0; btn_dec = 0; clk_1hz_en = 0; blink_en = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; clk_1hz_en = 0; blink_en = 0;
    cur_hour = 5'd9; cur_min = 6'd9;
    idle_cycles(3);
    n_cmp++;
    if ({time_count_en, load_en, hour_in, min_in, mode, blink_hour, blink_min}
        !== {1'b1, 1'b0, 5'd0, 6'd0, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got tce=%b ld=%b h=%0d m=%0d mode=%0d bh=%b bm=%b want 1 0 0 0 0 0 0",
               time_count_en, load_en, hour_in, min_in, mode, blink_hour, blink_min);
    end
    rst = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_full_set;
    int base;
    base = load_cnt;
    cur_hour = 5'd13; cur_min = 6'd45;
    pulse(1, 0, 0, 0, 0);
    n_cmp++;
    if ({mode, hour_in, min_in, time_count_en} !== {2'd1, 5'd13, 6'd45, 1'b0}) begin
      n_err++;
      $display("FAIL full_enter: got mode=%0d %0d:%0d tce=%b want 1 13:45 0",
               mode, hour_in, min_in, time_count_en);
    end
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    n_cmp++;
    if (hour_in !== 5'd15) begin
      n_err++;
      $display("FAIL full_inc_hour: got %0d want 15", hour_in);
    end
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    n_cmp++;
    if ({mode, min_in} !== {2'd2, 6'd44}) begin
      n_err++;
      $display("FAIL full_dec_min: got mode=%0d min=%0d want 2 44", mode, min_in);
    end
    pulse(1, 0, 0, 0, 0);
    n_cmp++;
    if ({mode, load_en, time_count_en, hour_in, min_in} !== {2'd3, 1'b1, 1'b0, 5'd15, 6'd44}) begin
      n_err++;
      $display("FAIL full_commit: got mode=%0d ld=%b tce=%b %0d:%0d want 3 1 0 15:44",
               mode, load_en, time_count_en, hour_in, min_in);
    end
    idle_cycles(2);
    #1;
    n_cmp++;
    if ({mode, load_en, time_count_en} !== {2'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL full_back_to_run: got mode=%0d ld=%b tce=%b want 0 0 1",
               mode, load_en, time_count_en);
    end
    n_cmp++;
    if (load_cnt - base !== 1) begin
      n_err++;
      $display("FAIL full_load_count: got %0d want 1", load_cnt - base);
    end
  endtask

  task automatic test_hour_wrap;
    cur_hour = 5'd23; cur_min = 6'd0;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    n_cmp++;
    if (hour_in !== 5'd0) begin
      n_err++;
      $display("FAIL hour_wrap_up: got %0d want 0", hour_in);
    end
    pulse(0, 0, 1, 0, 0);
    n_cmp++;
    if (hour_in !== 5'd23) begin
      n_err++;
      $display("FAIL hour_wrap_down: got %0d want 23", hour_in);
    end
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    idle_cycles(1);
  endtask

  task automatic test_min_wrap;
    cur_hour = 5'd5; cur_min = 6'd59;
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    n_cmp++;
    if (min_in !== 6'd0) begin
      n_err++;
      $display("FAIL min_wrap_up: got %0d want 0", min_in);
    end
    pulse(0, 0, 1, 0, 0);
    n_cmp++;
    if (min_in !== 6'd59) begin
      n_err++;
      $display("FAIL min_wrap_down: got %0d want 59", min_in);
    end
    // Left in SET_MIN with 05:59 for the next scenario.
  endtask

  task automatic test_simultaneous;
    pulse(0, 1, 1, 0, 0);
    n_cmp++;
    if ({mode, min_in} !== {2'd2, 6'd59}) begin
      n_err++;
      $display("FAIL inc_dec_together: got mode=%0d min=%0d want 2 59", mode, min_in);
    end
    pulse(1, 0, 0, 0, 0);
    idle_cycles(1);
    cur_hour = 5'd10; cur_min = 6'd20;
    pulse(1, 0, 0, 0, 0);
    pulse(1, 1, 0, 0, 0);
    n_cmp++;
    if ({mode, hour_in} !== {2'd2, 5'd10}) begin
      n_err++;
      $display("FAIL mode_inc_together: got mode=%0d hour=%0d want 2 10", mode, hour_in);
    end
    pulse(1, 0, 1, 0, 0);
    n_cmp++;
    if ({mode, min_in} !== {2'd3, 6'd20}) begin
      n_err++;
      $display("FAIL mode_dec_together: got mode=%0d min=%0d want 3 20", mode, min_in);
    end
    idle_cycles(1);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    n_cmp++;
    if ({mode, hour_in, min_in} !== {2'd0, 5'd10, 6'd20}) begin
      n_err++;
      $display("FAIL run_ignores_incdec: got mode=%0d %0d:%0d want 0 10:20",
               mode, hour_in, min_in);
    end
  endtask

  task automatic test_blink;
    cur_hour = 5'd10; cur_min = 6'd20;
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1);
    n_cmp++;
    if ({blink_hour, blink_min} !== 2'b10) begin
      n_err++;
      $display("FAIL blink_hour_on: got bh=%b bm=%b want 1 0", blink_hour, blink_min);
    end
    pulse(0, 1, 0, 0, 0);
    n_cmp++;
    if ({blink_hour, hour_in} !== {1'b0, 5'd11}) begin
      n_err++;
      $display("FAIL blink_cleared_by_btn: got bh=%b hour=%0d want 0 11", blink_hour, hour_in);
    end
    pulse(0, 0, 0, 0, 1);
    pulse(1, 0, 0, 0, 0);
    n_cmp++;
    if ({blink_hour, blink_min, mode} !== {1'b0, 1'b0, 2'd2}) begin
      n_err++;
      $display("FAIL blink_entry_clear: got bh=%b bm=%b mode=%0d want 0 0 2",
               blink_hour, blink_min, mode);
    end
    pulse(0, 0, 0, 0, 1);
    n_cmp++;
    if ({blink_hour, blink_min} !== 2'b01) begin
      n_err++;
      $display("FAIL blink_min_on: got bh=%b bm=%b want 0 1", blink_hour, blink_min);
    end
    pulse(1, 0, 0, 0, 0);
    n_cmp++;
    if ({blink_hour, blink_min, mode} !== {1'b0, 1'b0, 2'd3}) begin
      n_err++;
      $display("FAIL blink_commit_off: got bh=%b bm=%b mode=%0d want 0 0 3",
               blink_hour, blink_min, mode);
    end
    idle_cycles(1);
  endtask

  task automatic test_timeout;
    int base;
    cur_hour = 5'd1; cur_min = 6'd2;
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    base = load_cnt;
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 0, 1, 0);
    n_cmp++;
    if (mode !== 2'd2) begin
      n_err++;
      $display("FAIL timeout_early: got mode=%0d want 2 after 2 seconds", mode);
    end
    pulse(0, 0, 0, 1, 0);
    n_cmp++;
    if (mode !== 2'd2) begin
      n_err++;
      $display("FAIL timeout_reach: got mode=%0d want 2 on the count of 3", mode);
    end
    idle_cycles(1);
    #1;
    n_cmp++;
    if ({mode, time_count_en, load_en} !== {2'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_exit: got mode=%0d tce=%b ld=%b want 0 1 0",
               mode, time_count_en, load_en);
    end
    n_cmp++;
    if (load_cnt - base !== 0) begin
      n_err++;
      $display("FAIL timeout_no_load: got %0d strobes want 0", load_cnt - base);
    end
  endtask

  task automatic test_reset_mid_edit;
    int base;
    cur_hour = 5'd7; cur_min = 6'd30;
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    n_cmp++;
    if ({mode, min_in} !== {2'd2, 6'd31}) begin
      n_err++;
      $display("FAIL reset_setup: got mode=%0d min=%0d want 2 31", mode, min_in);
    end
    base = load_cnt;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({time_count_en, load_en, hour_in, min_in, mode, blink_hour, blink_min}
        !== {1'b1, 1'b0, 5'd0, 6'd0, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async: got tce=%b ld=%b h=%0d m=%0d mode=%0d bh=%b bm=%b want 1 0 0 0 0 0 0",
               time_count_en, load_en, hour_in, min_in, mode, blink_hour, blink_min);
    end
    // A mode press while reset is held must not start an edit.
    pulse(1, 0, 0, 0, 0);
    rst = 1'b0;
    idle_cycles(2);
    #1;
    n_cmp++;
    if ({mode, time_count_en, load_cnt - base} !== {2'd0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL reset_after: got mode=%0d tce=%b loads=%0d want 0 1 0",
               mode, time_count_en, load_cnt - base);
    end
  endtask

  initial begin
    test_reset;
    test_full_set;
    test_hour_wrap;
    test_min_wrap;
    test_simultaneous;
    test_blink;
    test_timeout;
    test_reset_mid_edit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
